// File: rtl/avst_sideband_delay_line.sv
// Avalon-ST sideband delay line: DEPTH-stage valid/sop/eop/sb pipeline with advance enable,
// flush, in-flight counter and a free-running ready delay. Macro AVST_SIDEBAND_DELAY_PKT_CHECK_EN
// enables the framing checker on output beats.
//
// state     | meaning
// ST_IDLE   | between packets, next output beat must carry sop
// ST_IN_PKT | inside a packet, waiting for eop
module avst_sideband_delay_line #(
    parameter  int DEPTH = 5,
    parameter  int SB_W  = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             flush,
    input  logic             src_ready_i,
    input  logic             snk_valid_i,
    input  logic             snk_sop_i,
    input  logic             snk_eop_i,
    input  logic [SB_W-1:0]  snk_sb_i,
    output logic             sync_ready_o,
    output logic             sync_valid_o,
    output logic             sync_sop_o,
    output logic             sync_eop_o,
    output logic [SB_W-1:0]  sync_sb_o,
    output logic [CNT_W-1:0] inflight_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    logic [DEPTH-1:0] rdy_q;
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] sop_q;
    logic [DEPTH-1:0] eop_q;
    logic [SB_W-1:0]  sb_q [DEPTH];
    logic [CNT_W-1:0] inflight_q;

    // Ready path runs free so the downstream handshake never stalls behind ce/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= '0;
        end else begin
            rdy_q[0] <= src_ready_i;
            for (int k = 1; k < DEPTH; k++) begin
                rdy_q[k] <= rdy_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sop_q <= '0;
            eop_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
            sop_q <= '0;
            eop_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else if (ce) begin
            vld_q[0] <= snk_valid_i;
            sop_q[0] <= snk_sop_i & snk_valid_i;
            eop_q[0] <= snk_eop_i & snk_valid_i;
            sb_q[0]  <= snk_sb_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                sop_q[k] <= sop_q[k-1];
                eop_q[k] <= eop_q[k-1];
                sb_q[k]  <= sb_q[k-1];
            end
        end
    end

    // Entering and leaving beat in the same advance cancel, so the count tracks stage popcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else if (flush) begin
            inflight_q <= '0;
        end else if (ce) begin
            inflight_q <= inflight_q + CNT_W'(snk_valid_i) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    assign sync_ready_o = rdy_q[DEPTH-1];
    assign sync_valid_o = vld_q[DEPTH-1];
    assign sync_sop_o   = sop_q[DEPTH-1];
    assign sync_eop_o   = eop_q[DEPTH-1];
    assign sync_sb_o    = sb_q[DEPTH-1];
    assign inflight_o   = inflight_q;
    assign busy_o       = (inflight_q != '0);

`ifdef AVST_SIDEBAND_DELAY_PKT_CHECK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    logic [0:0] state_q, state_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic       out_beat;
    logic       viol;
    logic [1:0] viol_code;

    assign out_beat = vld_q[DEPTH-1] & ce;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        code_d    = code_q;
        viol      = 1'b0;
        viol_code = 2'b00;
        if (flush) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
            code_d  = 2'b00;
        end else if (out_beat) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sop_q[DEPTH-1]) begin
                        viol      = 1'b1;
                        viol_code = 2'b01;
                    end else if (!eop_q[DEPTH-1]) begin
                        state_d = ST_IN_PKT;
                    end
                end
                default: begin
                    if (sop_q[DEPTH-1]) begin
                        viol      = 1'b1;
                        viol_code = 2'b10;
                    end
                    if (eop_q[DEPTH-1]) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
            // First error wins; later violations leave the recorded code alone.
            if (viol && !err_q) begin
                err_d  = 1'b1;
                code_d = viol_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign err_o      = err_q;
    assign err_code_o = code_q;
`else
    assign err_o      = 1'b0;
    assign err_code_o = 2'b00;
`endif

endmodule

// File: tb/tb_avst_sideband_delay_line.sv
// Scoreboard bench for avst_sideband_delay_line (DEPTH=5): stimulus queues expected beats with
// their exit cycle, a negedge monitor pops and compares them; ready delay checked from history.
module tb_avst_sideband_delay_line;
    localparam int DEPTH = 5;
    localparam int SB_W  = 2;
    localparam int CNT_W = 3;
`ifdef AVST_SIDEBAND_DELAY_PKT_CHECK_EN
    localparam bit PKT_CHK = 1'b1;
`else
    localparam bit PKT_CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ce = 1'b0;
    logic             flush = 1'b0;
    logic             src_ready_i = 1'b0;
    logic             snk_valid_i = 1'b0;
    logic             snk_sop_i = 1'b0;
    logic             snk_eop_i = 1'b0;
    logic [SB_W-1:0]  snk_sb_i = '0;
    logic             sync_ready_o, sync_valid_o, sync_sop_o, sync_eop_o;
    logic [SB_W-1:0]  sync_sb_o;
    logic [CNT_W-1:0] inflight_o;
    logic             busy_o, err_o;
    logic [1:0]       err_code_o;

    avst_sideband_delay_line #(.DEPTH(DEPTH), .SB_W(SB_W)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .src_ready_i(src_ready_i),
        .snk_valid_i(snk_valid_i), .snk_sop_i(snk_sop_i), .snk_eop_i(snk_eop_i),
        .snk_sb_i(snk_sb_i), .sync_ready_o(sync_ready_o), .sync_valid_o(sync_valid_o),
        .sync_sop_o(sync_sop_o), .sync_eop_o(sync_eop_o), .sync_sb_o(sync_sb_o),
        .inflight_o(inflight_o), .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rst_cyc = 0;
    int total = 0;
    int bad = 0;
    logic rhist [0:8191];

    always @(posedge clk) cyc++;

    typedef struct {
        logic            sop;
        logic            eop;
        logic [SB_W-1:0] sb;
        int              at;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: invariants plus scoreboard pops on each output beat.
    always @(negedge clk) begin
        exp_t e;
        logic rexp;
        rhist[cyc] = src_ready_i;
        if (rst_n) begin
            chk("sop_eop_qualified", {31'd0, !sync_valid_o && (sync_sop_o || sync_eop_o)}, 0);
            chk("busy", {31'd0, busy_o}, {31'd0, inflight_o != 0});
            rexp = (cyc - 5 >= rst_cyc) ? rhist[cyc-5] : 1'b0;
            chk("ready_delay", {31'd0, sync_ready_o}, {31'd0, rexp});
            if (sync_valid_o && ce) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("beat_sop", {31'd0, sync_sop_o}, {31'd0, e.sop});
                    chk("beat_eop", {31'd0, sync_eop_o}, {31'd0, e.eop});
                    chk("beat_sb", {30'd0, sync_sb_o}, {30'd0, e.sb});
                    chk("beat_cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [SB_W-1:0] sb, input logic c, input logic f);
        snk_valid_i = v;
        snk_sop_i   = s;
        snk_eop_i   = e;
        snk_sb_i    = sb;
        ce          = c;
        flush       = f;
        src_ready_i = ((cyc ^ (cyc >> 2)) & 1) != 0;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic s, input logic e, input logic [SB_W-1:0] sb, input int lat);
        sbq.push_back('{s, e, sb, cyc + lat});
        drive(1'b1, s, e, sb, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_valid", {31'd0, sync_valid_o}, 0);
        chk("rst_ready", {31'd0, sync_ready_o}, 0);
        chk("rst_inflight", {29'd0, inflight_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rst_cyc = cyc;
        idle(2);

        // 1: single sop+eop beat, latency 5, counter 1 for cycles 1..5
        beat(1'b1, 1'b1, 2'd1, 5);
        for (int i = 1; i <= 5; i++) begin
            chk("t1_inflight_one", {29'd0, inflight_o}, 1);
            idle(1);
        end
        chk("t1_inflight_zero", {29'd0, inflight_o}, 0);
        chk("t1_busy_zero", {31'd0, busy_o}, 0);
        idle(3);

        // 2: 4-beat packet with 3-cycle stall after beat 2, exits at 8..11
        beat(1'b1, 1'b0, 2'd2, 8);
        beat(1'b0, 1'b0, 2'd3, 8);
        beat(1'b0, 1'b0, 2'd0, 8);
        repeat (3) begin
            drive(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
            chk("t2_frozen_inflight", {29'd0, inflight_o}, 3);
            chk("t2_frozen_valid", {31'd0, sync_valid_o}, 0);
        end
        beat(1'b0, 1'b1, 2'd1, 5);
        idle(8);

        // 3: flush with 4 beats in flight and a concurrent beat
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, i == 3, 2'(i), 1'b1, 1'b0);
        chk("t3_inflight_four", {29'd0, inflight_o}, 4);
        drive(1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1);
        chk("t3_flush_valid", {31'd0, sync_valid_o}, 0);
        chk("t3_flush_inflight", {29'd0, inflight_o}, 0);
        chk("t3_flush_busy", {31'd0, busy_o}, 0);
        idle(8);

        // 4: continuous stream saturates the counter at DEPTH
        for (int i = 0; i < 20; i++) begin
            beat(i == 0, i == 19, 2'(i), 5);
            chk("t4_inflight", {29'd0, inflight_o}, (i + 1 < 5) ? i + 1 : 5);
        end
        repeat (6) drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
        chk("t4_drained", {29'd0, inflight_o}, 0);
        idle(3);

        // 5: async reset mid-packet, then a fresh beat
        for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, 2'd1, 1'b1, 1'b0);
        chk("t5_inflight_three", {29'd0, inflight_o}, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, sync_valid_o}, 0);
        chk("t5_rst_inflight", {29'd0, inflight_o}, 0);
        chk("t5_rst_busy", {31'd0, busy_o}, 0);
        chk("t5_rst_ready", {31'd0, sync_ready_o}, 0);
        sbq.delete();
        snk_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rst_cyc = cyc;
        beat(1'b1, 1'b1, 2'd2, 5);
        idle(7);

        // 6: framing checker
        chk("t6_err_clean", {31'd0, err_o}, 0);
        beat(1'b0, 1'b0, 2'd1, 5);
        idle(4);
        chk("t6_err_not_yet", {31'd0, err_o}, 0);
        idle(1);
        chk("t6_err_set", {31'd0, err_o}, {31'd0, PKT_CHK});
        chk("t6_code_01", {30'd0, err_code_o}, PKT_CHK ? 1 : 0);
        beat(1'b1, 1'b0, 2'd0, 5);
        beat(1'b1, 1'b1, 2'd3, 5);
        idle(7);
        chk("t6_err_sticky", {31'd0, err_o}, {31'd0, PKT_CHK});
        chk("t6_code_kept", {30'd0, err_code_o}, PKT_CHK ? 1 : 0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("t6_flush_err", {31'd0, err_o}, 0);
        chk("t6_flush_code", {30'd0, err_code_o}, 0);
        idle(3);

        chk("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
